// File: rtl/lsu_unit.sv
// Load/store unit for the RV32I execute/memory path.
// Accepts one memory operation at a time, steers byte lanes, detects
// misaligned and illegal-width accesses, and extends load results.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | req_ready high, waiting for an operation from execute
// ACCESS | mem_req held with stable address/data until mem_ack
// RESP   | one-cycle rsp_valid pulse carrying result or fault flags

module lsu_unit #(
   parameter int AW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [2:0]    req_funct3,
   input  logic [AW-1:0] req_addr,
   input  logic [AW-1:0] req_wdata,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [AW-1:0] mem_wdata,
   output logic [3:0]    mem_be,
   input  logic          mem_ack,
   input  logic [AW-1:0] mem_rdata,
   output logic          rsp_valid,
   output logic [AW-1:0] rsp_rdata,
   output logic          misaligned,
   output logic          illegal
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    off_q, off_d;
   logic [2:0]    f3_q, f3_d;

   logic          mem_req_d, mem_we_d, rsp_valid_d, misaligned_d, illegal_d;
   logic [AW-1:0] mem_addr_d, mem_wdata_d, rsp_rdata_d;
   logic [3:0]    mem_be_d;

   logic          ill_in, mis_in;
   logic [3:0]    be_in;
   logic [AW-1:0] wdata_in;
   logic [AW-1:0] lane, ext;

   assign req_ready = (state_q == IDLE);

   // Decode the incoming request: legality, alignment, lanes and store data.
   always_comb begin
      ill_in   = 1'b0;
      mis_in   = 1'b0;
      be_in    = 4'b1111;
      wdata_in = '0;
      // Stores only have B/H/W; loads additionally allow BU/HU.
      if (req_we)
         ill_in = req_funct3[2] | (req_funct3[1:0] == 2'b11);
      else
         ill_in = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11);
      case (req_funct3[1:0])
         2'b00:   be_in = 4'b0001 << req_addr[1:0];
         2'b01: begin
            be_in  = 4'b0011 << req_addr[1:0];
            mis_in = req_addr[0];
         end
         default: begin
            be_in  = 4'b1111;
            mis_in = |req_addr[1:0];
         end
      endcase
      // An illegal width never reports misalignment.
      mis_in = mis_in & ~ill_in;
      if (req_we) begin
         case (req_funct3[1:0])
            2'b00:   wdata_in = {4{req_wdata[7:0]}};
            2'b01:   wdata_in = {2{req_wdata[15:0]}};
            default: wdata_in = req_wdata;
         endcase
      end
   end

   // Shift the addressed lane down and extend according to the latched width.
   always_comb begin
      lane = mem_rdata >> {off_q, 3'b000};
      case (f3_q)
         3'b000:  ext = {{(AW-8){lane[7]}}, lane[7:0]};
         3'b100:  ext = {{(AW-8){1'b0}}, lane[7:0]};
         3'b001:  ext = {{(AW-16){lane[15]}}, lane[15:0]};
         3'b101:  ext = {{(AW-16){1'b0}}, lane[15:0]};
         default: ext = lane;
      endcase
   end

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_d      = state_q;
      off_d        = off_q;
      f3_d         = f3_q;
      mem_req_d    = mem_req;
      mem_we_d     = mem_we;
      mem_addr_d   = mem_addr;
      mem_wdata_d  = mem_wdata;
      mem_be_d     = mem_be;
      rsp_valid_d  = rsp_valid;
      rsp_rdata_d  = rsp_rdata;
      misaligned_d = misaligned;
      illegal_d    = illegal;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               off_d = req_addr[1:0];
               f3_d  = req_funct3;
               if (ill_in | mis_in) begin
                  state_d      = RESP;
                  rsp_valid_d  = 1'b1;
                  rsp_rdata_d  = '0;
                  illegal_d    = ill_in;
                  misaligned_d = mis_in;
               end else begin
                  state_d     = ACCESS;
                  mem_req_d   = 1'b1;
                  mem_we_d    = req_we;
                  mem_addr_d  = {req_addr[AW-1:2], 2'b00};
                  mem_be_d    = be_in;
                  mem_wdata_d = wdata_in;
               end
            end
         end
         ACCESS: begin
            if (mem_ack) begin
               state_d     = RESP;
               mem_req_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = mem_we ? '0 : ext;
            end
         end
         RESP: begin
            state_d      = IDLE;
            rsp_valid_d  = 1'b0;
            misaligned_d = 1'b0;
            illegal_d    = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset abandons any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         off_q      <= '0;
         f3_q       <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_be     <= '0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         misaligned <= 1'b0;
         illegal    <= 1'b0;
      end else begin
         state_q    <= state_d;
         off_q      <= off_d;
         f3_q       <= f3_d;
         mem_req    <= mem_req_d;
         mem_we     <= mem_we_d;
         mem_addr   <= mem_addr_d;
         mem_wdata  <= mem_wdata_d;
         mem_be     <= mem_be_d;
         rsp_valid  <= rsp_valid_d;
         rsp_rdata  <= rsp_rdata_d;
         misaligned <= misaligned_d;
         illegal    <= illegal_d;
      end
   end

endmodule

// File: tb/tb_lsu_unit.sv
// Directed bench for lsu_unit: each task drives one scenario and checks
// the outputs against hand-computed values.

module tb_lsu_unit;

   logic        clk, rst_n;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        rsp_valid, misaligned, illegal;
   logic [31:0] rsp_rdata;

   int n_cmp = 0;
   int n_err = 0;

   // Observations from the last run_op transaction.
   int          o_req_cycles, o_rsp_cnt, o_rsp_cycle;
   logic [31:0] o_rdata, o_addr, o_wdata;
   logic [3:0]  o_be;
   logic        o_we, o_mis, o_ill, o_stable;

   lsu_unit #(.AW(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .misaligned(misaligned), .illegal(illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Present one request, model memory acking in the ack_delay-th mem_req
   // cycle, and record what the DUT did over a bounded window.
   task automatic run_op(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int ack_delay);
      o_req_cycles = 0;
      o_rsp_cnt    = 0;
      o_rsp_cycle  = -1;
      o_rdata      = 32'hxxxx_xxxx;
      o_addr       = 32'hxxxx_xxxx;
      o_wdata      = 32'hxxxx_xxxx;
      o_be         = 4'hx;
      o_we         = 1'bx;
      o_mis        = 1'bx;
      o_ill        = 1'bx;
      o_stable     = 1'b1;
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      mem_rdata  = rdata;
      mem_ack    = 1'b0;
      tick;
      req_valid = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         if (mem_req) begin
            o_req_cycles++;
            if (o_req_cycles == 1) begin
               o_addr  = mem_addr;
               o_wdata = mem_wdata;
               o_be    = mem_be;
               o_we    = mem_we;
            end else if (mem_addr !== o_addr || mem_wdata !== o_wdata ||
                         mem_be !== o_be || mem_we !== o_we) begin
               o_stable = 1'b0;
            end
         end
         mem_ack = mem_req && (o_req_cycles == ack_delay);
         if (rsp_valid) begin
            o_rsp_cnt++;
            if (o_rsp_cnt == 1) begin
               o_rsp_cycle = c;
               o_rdata     = rsp_rdata;
               o_mis       = misaligned;
               o_ill       = illegal;
            end
         end
         tick;
      end
      mem_ack = 1'b0;
   endtask

   task automatic test_reset;
      #3;
      if (mem_req !== 1'b0 || rsp_valid !== 1'b0) begin
         n_err++; $display("FAIL rst_held mem_req=%b rsp_valid=%b exp 0 0", mem_req, rsp_valid);
      end
      n_cmp++;
      #19 rst_n = 1'b1;
      tick;
      if (req_ready !== 1'b1) begin
         n_err++; $display("FAIL rst_ready got=%b exp=1", req_ready);
      end
      n_cmp++;
      if ({mem_req, mem_we, mem_be} !== 6'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
         n_err++; $display("FAIL rst_mem req=%b we=%b be=%b addr=%h wdata=%h exp all 0",
                           mem_req, mem_we, mem_be, mem_addr, mem_wdata);
      end
      n_cmp++;
      if ({rsp_valid, misaligned, illegal} !== 3'b0 || rsp_rdata !== 32'h0) begin
         n_err++; $display("FAIL rst_rsp valid=%b mis=%b ill=%b rdata=%h exp all 0",
                           rsp_valid, misaligned, illegal, rsp_rdata);
      end
      n_cmp++;
   endtask

   task automatic test_sw_wait;
      run_op(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 3);
      if (o_req_cycles !== 3) begin
         n_err++; $display("FAIL sw_req_cycles got=%0d exp=3", o_req_cycles);
      end
      n_cmp++;
      if (o_addr !== 32'h100 || o_be !== 4'b1111 || o_wdata !== 32'hDEAD_BEEF || o_we !== 1'b1) begin
         n_err++; $display("FAIL sw_mem addr=%h be=%b wdata=%h we=%b exp 00000100 1111 deadbeef 1",
                           o_addr, o_be, o_wdata, o_we);
      end
      n_cmp++;
      if (o_stable !== 1'b1) begin
         n_err++; $display("FAIL sw_stable got=%b exp=1", o_stable);
      end
      n_cmp++;
      if (o_rsp_cnt !== 1 || o_rsp_cycle !== 4 || o_rdata !== 32'h0) begin
         n_err++; $display("FAIL sw_rsp cnt=%0d cycle=%0d rdata=%h exp 1 4 00000000",
                           o_rsp_cnt, o_rsp_cycle, o_rdata);
      end
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_err++; $display("FAIL sw_ready_after got=%b exp=1", req_ready);
      end
      n_cmp++;
   endtask

   task automatic test_byte_loads;
      run_op(1'b0, 3'b000, 32'h0000_0203, 32'hFFFF_FFFF, 32'h8012_3456, 1);
      if (o_addr !== 32'h200 || o_be !== 4'b1000 || o_wdata !== 32'h0 || o_we !== 1'b0) begin
         n_err++; $display("FAIL lb_mem addr=%h be=%b wdata=%h we=%b exp 00000200 1000 00000000 0",
                           o_addr, o_be, o_wdata, o_we);
      end
      n_cmp++;
      if (o_rdata !== 32'hFFFF_FF80 || o_rsp_cycle !== 2 || o_rsp_cnt !== 1) begin
         n_err++; $display("FAIL lb_rsp rdata=%h cycle=%0d cnt=%0d exp ffffff80 2 1",
                           o_rdata, o_rsp_cycle, o_rsp_cnt);
      end
      n_cmp++;
      run_op(1'b0, 3'b100, 32'h0000_0203, 32'h0, 32'h8012_3456, 1);
      if (o_rdata !== 32'h0000_0080) begin
         n_err++; $display("FAIL lbu_rsp rdata=%h exp 00000080", o_rdata);
      end
      n_cmp++;
      run_op(1'b0, 3'b000, 32'h0000_0201, 32'h0, 32'h8012_3456, 1);
      if (o_be !== 4'b0010 || o_rdata !== 32'h0000_0034) begin
         n_err++; $display("FAIL lb_off1 be=%b rdata=%h exp 0010 00000034", o_be, o_rdata);
      end
      n_cmp++;
   endtask

   task automatic test_half;
      run_op(1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 32'h0, 2);
      if (o_addr !== 32'h100 || o_be !== 4'b1100 || o_wdata !== 32'hABCD_ABCD) begin
         n_err++; $display("FAIL sh_mem addr=%h be=%b wdata=%h exp 00000100 1100 abcdabcd",
                           o_addr, o_be, o_wdata);
      end
      n_cmp++;
      run_op(1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h8001_FFFF, 1);
      if (o_rdata !== 32'hFFFF_8001 || o_be !== 4'b1100) begin
         n_err++; $display("FAIL lh_rsp rdata=%h be=%b exp ffff8001 1100", o_rdata, o_be);
      end
      n_cmp++;
      run_op(1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h8001_FFFF, 1);
      if (o_rdata !== 32'h0000_8001) begin
         n_err++; $display("FAIL lhu_rsp rdata=%h exp 00008001", o_rdata);
      end
      n_cmp++;
      run_op(1'b1, 3'b000, 32'h0000_0301, 32'h0000_00A5, 32'h0, 1);
      if (o_be !== 4'b0010 || o_wdata !== 32'hA5A5_A5A5) begin
         n_err++; $display("FAIL sb_mem be=%b wdata=%h exp 0010 a5a5a5a5", o_be, o_wdata);
      end
      n_cmp++;
   endtask

   task automatic test_faults;
      run_op(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h5555_5555, 1);
      if (o_mis !== 1'b1 || o_ill !== 1'b0 || o_rsp_cycle !== 1 || o_rsp_cnt !== 1) begin
         n_err++; $display("FAIL lw_misalign mis=%b ill=%b cycle=%0d cnt=%0d exp 1 0 1 1",
                           o_mis, o_ill, o_rsp_cycle, o_rsp_cnt);
      end
      n_cmp++;
      if (o_req_cycles !== 0 || o_rdata !== 32'h0) begin
         n_err++; $display("FAIL lw_misalign_mem req_cycles=%0d rdata=%h exp 0 00000000",
                           o_req_cycles, o_rdata);
      end
      n_cmp++;
      run_op(1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h5555_5555, 1);
      if (o_ill !== 1'b1 || o_mis !== 1'b0 || o_req_cycles !== 0 || o_rdata !== 32'h0) begin
         n_err++; $display("FAIL ld_f3_011 ill=%b mis=%b req_cycles=%0d rdata=%h exp 1 0 0 00000000",
                           o_ill, o_mis, o_req_cycles, o_rdata);
      end
      n_cmp++;
      run_op(1'b1, 3'b100, 32'h0000_0100, 32'h0, 32'h0, 1);
      if (o_ill !== 1'b1 || o_req_cycles !== 0) begin
         n_err++; $display("FAIL st_f3_100 ill=%b req_cycles=%0d exp 1 0", o_ill, o_req_cycles);
      end
      n_cmp++;
      run_op(1'b1, 3'b101, 32'h0000_0101, 32'h0, 32'h0, 1);
      if (o_ill !== 1'b1 || o_mis !== 1'b0) begin
         n_err++; $display("FAIL ill_priority ill=%b mis=%b exp 1 0", o_ill, o_mis);
      end
      n_cmp++;
      run_op(1'b0, 3'b110, 32'h0000_0100, 32'h0, 32'h0, 1);
      if (o_ill !== 1'b1) begin
         n_err++; $display("FAIL ld_f3_110 ill=%b exp 1", o_ill);
      end
      n_cmp++;
   endtask

   task automatic test_reset_mid;
      int rsp_seen;
      rsp_seen   = 0;
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h0000_0040;
      mem_ack    = 1'b0;
      tick;
      req_valid = 1'b0;
      if (mem_req !== 1'b1) begin
         n_err++; $display("FAIL rmid_in_access mem_req=%b exp 1", mem_req);
      end
      n_cmp++;
      #2 rst_n = 1'b0;
      #1;
      if (mem_req !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         n_err++; $display("FAIL rmid_async mem_req=%b ready=%b rsp_valid=%b exp 0 1 0",
                           mem_req, req_ready, rsp_valid);
      end
      n_cmp++;
      tick;
      tick;
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (rsp_valid || mem_req) rsp_seen++;
         tick;
      end
      if (rsp_seen !== 0) begin
         n_err++; $display("FAIL rmid_no_rsp active_cycles=%0d exp 0", rsp_seen);
      end
      n_cmp++;
      run_op(1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'h1122_3344, 1);
      if (o_rdata !== 32'h1122_3344 || o_addr !== 32'h10 || o_rsp_cnt !== 1) begin
         n_err++; $display("FAIL rmid_after_lw rdata=%h addr=%h cnt=%0d exp 11223344 00000010 1",
                           o_rdata, o_addr, o_rsp_cnt);
      end
      n_cmp++;
   endtask

   task automatic test_back_to_back;
      int acc_a, acc_b, rsp_n, rsp1_c, rsp2_c;
      logic [31:0] rsp1_d, rsp2_d;
      acc_a = -1; acc_b = -1; rsp_n = 0; rsp1_c = -1; rsp2_c = -1;
      rsp1_d = 32'hxxxx_xxxx; rsp2_d = 32'hxxxx_xxxx;
      // Stray ack while idle with no request.
      req_valid = 1'b0;
      mem_ack   = 1'b1;
      tick;
      mem_ack = 1'b0;
      if (mem_req !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_err++; $display("FAIL stray_ack mem_req=%b rsp_valid=%b ready=%b exp 0 0 1",
                           mem_req, rsp_valid, req_ready);
      end
      n_cmp++;
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h0000_0020;
      for (int t = 0; t < 12; t++) begin
         mem_ack   = (t == 0) ? 1'b1 : mem_req;
         mem_rdata = (mem_addr == 32'h24) ? 32'hBBBB_0002 : 32'hAAAA_0001;
         if (rsp_valid) begin
            rsp_n++;
            if (rsp_n == 1) begin rsp1_c = t; rsp1_d = rsp_rdata; end
            else begin rsp2_c = t; rsp2_d = rsp_rdata; end
         end
         if (req_valid && req_ready) begin
            if (acc_a < 0) acc_a = t;
            else acc_b = t;
         end
         tick;
         if (acc_a == t) req_addr = 32'h0000_0024;
         if (acc_b == t) req_valid = 1'b0;
      end
      mem_ack   = 1'b0;
      req_valid = 1'b0;
      if (acc_a !== 0 || acc_b !== 3) begin
         n_err++; $display("FAIL b2b_accept a=%0d b=%0d exp 0 3", acc_a, acc_b);
      end
      n_cmp++;
      if (rsp_n !== 2 || rsp1_c !== 2 || rsp2_c !== 5) begin
         n_err++; $display("FAIL b2b_rsp_timing cnt=%0d c1=%0d c2=%0d exp 2 2 5",
                           rsp_n, rsp1_c, rsp2_c);
      end
      n_cmp++;
      if (rsp1_d !== 32'hAAAA_0001 || rsp2_d !== 32'hBBBB_0002) begin
         n_err++; $display("FAIL b2b_data d1=%h d2=%h exp aaaa0001 bbbb0002", rsp1_d, rsp2_d);
      end
      n_cmp++;
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      mem_ack    = 1'b0;
      mem_rdata  = 32'h0;
      test_reset;
      test_sw_wait;
      test_byte_loads;
      test_half;
      test_faults;
      test_reset_mid;
      test_back_to_back;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
